uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Asynchronous 8N1 UART receiver; receive-side counterpart of the uart TX block on clk100.
//  Oversamples rx_pin, recovers bytes, presents them on a level-valid/ack handshake to the test
//  and control FSMs. Reports frame errors and overruns.
// PARAMETERS
//  CLK_HZ      100_000_000  system clock frequency
//  BAUD        115200       line rate
//  OVERSAMPLE  16           samples per bit; even, >=8
//  DIV         CLK_HZ/(BAUD*OVERSAMPLE) rounded to nearest integer (54 at defaults); localparam
// PORTS
//  clk           in   1  system clock (clk100)
//  rst           in   1  asynchronous, active-low reset
//  rx_pin        in   1  serial line, idle high, asynchronous to clk
//  rx_data       out  8  last received byte, LSB first on line
//  rx_valid      out  1  high while rx_data holds an unacknowledged byte
//  rx_ack        in   1  consumer pulse; clears rx_valid
//  rx_busy       out  1  high from start-edge detect to end of stop bit
//  rx_frame_err  out  1  1-cycle pulse: stop bit sampled low
//  rx_overrun    out  1  1-cycle pulse: byte completed while rx_valid still high
// BEHAVIOUR
//  Reset: one clock, asynchronous, active low. All outputs 0; FSM=IDLE; synchroniser flops preset to 1.
//  Input: 2-FF synchroniser on rx_pin, then a third flop for falling-edge detect.
//  Tick: counter 0..DIV-1, one-cycle tick on wrap; counter forced to 0 on the IDLE->START transition.
//  Sample: sub-bit counter 0..OVERSAMPLE-1 advances on tick. Bit value = majority of the samples
//   at indices OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1. Bit ends when the count wraps.
//  FSM:
//   IDLE:   synced line falls -> START.
//   START:  at mid-bit vote==1 -> IDLE (glitch, no flags); at bit end -> DATA, bit_idx=0.
//   DATA:   shift vote in at MSB (right shift), so rx_pin LSB-first ends in data[0].
//           After bit_idx==7 ends -> STOP.
//   STOP:   decision at mid-bit; does not wait for bit end, so the next start edge is caught early.
//           vote==1: rx_data<=shreg; rx_valid<=1; -> IDLE.
//             If rx_valid was already 1 and no ack this cycle: pulse rx_overrun, data overwritten.
//           vote==0: pulse rx_frame_err; rx_data and rx_valid untouched; -> BREAK.
//   BREAK:  wait until synced line ==1, then -> IDLE. A held-low line yields exactly one frame_err.
//  rx_busy = (state != IDLE).
//  Handshake:
//   rx_ack with rx_valid=1 clears it next cycle.
//   rx_ack with rx_valid=0 is ignored.
//   Same-cycle ack and new-byte store: store wins, rx_valid stays 1, no overrun.
//  Latency: rx_valid rises 2 clks after the mid-stop tick (sync + register). Worst case about
//   9.5 bit times after the start edge.
//  Tolerance: sender/receiver rate mismatch up to +/-3% must decode correctly.
//  Reset mid-frame: returns to IDLE at once. A partial frame never sets rx_valid; the next clean
//   start edge is received.
// STRUCTURE
//  uart_defs.vh (shared with uart TX): FSM state encodings IDLE/START/DATA/STOP/BREAK,
//   DIV computation macro, default CLK_HZ/BAUD.
//  Sub-module uart_baud_tick (DIV counter + clear input, tick output); the TX side can reuse it.
//  Everything else (synchroniser, voter, FSM, shifter, output regs) lives in uart_rx.
// TESTING (100 MHz clk, 115200 baud, bit = 864 clks, bench drives rx_pin)
//  1. Send 0x55, ack 10 clks after rx_valid -> rx_data=8'h55, rx_valid high until ack+1, no error flags.
//  2. Back-to-back 0xA5 then 0x3C, no idle gap, ack each promptly
//     -> two valids, data 8'hA5 then 8'h3C, rx_busy low only between frames.
//  3. rx_pin low for 200 ns, then high -> START aborts, no rx_valid, no rx_frame_err,
//     rx_busy returns to 0 within 1 bit.
//  4. Send 0x81 with stop bit driven low, then line high
//     -> one rx_frame_err pulse, rx_valid stays 0, following 0x42 decodes correctly.
//  5. Send 0x11 and 0x22 without ack -> rx_overrun pulses once at the second byte,
//     rx_data=8'h22, rx_valid=1.
//  6. Assert rst low mid-DATA of 0xF0, release, send 0x0F at 3% fast rate
//     -> outputs 0 during reset, only 0x0F delivered.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// default line settings and the baud divider calculation.
package uart_rx_pkg;

  localparam int unsigned DEF_CLK_HZ     = 100_000_000;
  localparam int unsigned DEF_BAUD       = 115_200;
  localparam int unsigned DEF_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running 0..DIV-1 counter producing a one-cycle tick on wrap;
// clr restarts the count so the first tick lands DIV clocks later.
module uart_baud_tick #(
  parameter int unsigned DIV = 54
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(DIV - 1));

  always_comb begin
    // NOTE: default assignment first, so every path drives cnt_d and no latch is inferred.
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) cnt_d = '0;
  end

  // NOTE: non-blocking assignments in clocked blocks, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchroniser, oversampled 3-point majority vote,
// frame FSM and a level-valid/ack output register with error pulses.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_HZ     = DEF_CLK_HZ,
  parameter int unsigned BAUD       = DEF_BAUD,
  parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_busy,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int unsigned DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int          SW  = $clog2(OVERSAMPLE);

  localparam logic [SW-1:0] IDX_LO  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] IDX_MID = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] IDX_HI  = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] IDX_END = SW'(OVERSAMPLE - 1);

  logic [2:0]    sync_q, sync_d;
  rx_state_e     state_q, state_d;
  logic [SW-1:0] samp_q, samp_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          smp_lo_q, smp_lo_d;
  logic          smp_mid_q, smp_mid_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;

  logic line, fall, tick, start_go, mid_tick, end_tick, vote;

  // sync_q[1] is the synchronised line; sync_q[2] only exists for edge detect.
  assign sync_d   = {sync_q[1:0], rx_pin};
  assign line     = sync_q[1];
  assign fall     = sync_q[2] & ~sync_q[1];
  assign start_go = (state_q == ST_IDLE) && fall;
  assign mid_tick = tick && (samp_q == IDX_HI);
  assign end_tick = tick && (samp_q == IDX_END);
  // Third sample is taken live at the mid_tick instant.
  assign vote     = (smp_lo_q & smp_mid_q) | (smp_lo_q & line) | (smp_mid_q & line);

  uart_baud_tick #(.DIV(DIV)) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_go),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (fall) state_d = ST_START;
      ST_START: begin
        if (mid_tick && vote) state_d = ST_IDLE;
        else if (end_tick)    state_d = ST_DATA;
      end
      ST_DATA:  if (end_tick && bit_idx_q == 3'd7) state_d = ST_STOP;
      // Decide at mid-stop so a back-to-back start edge is not missed.
      ST_STOP:  if (mid_tick) state_d = vote ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (line) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    samp_d      = samp_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    smp_lo_d    = smp_lo_q;
    smp_mid_d   = smp_mid_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q && !rx_ack;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (start_go) begin
      samp_d = '0;
    end else if (tick && state_q != ST_IDLE) begin
      samp_d = (samp_q == IDX_END) ? '0 : samp_q + SW'(1);
    end

    if (tick && samp_q == IDX_LO)  smp_lo_d  = line;
    if (tick && samp_q == IDX_MID) smp_mid_d = line;

    unique case (state_q)
      ST_START: if (end_tick) bit_idx_d = 3'd0;
      ST_DATA: begin
        if (mid_tick) shreg_d   = {vote, shreg_q[7:1]};
        if (end_tick) bit_idx_d = bit_idx_q + 3'd1;
      end
      ST_STOP: begin
        if (mid_tick) begin
          if (vote) begin
            // A store in the same cycle as an ack wins and is not an overrun.
            rx_data_d  = shreg_q;
            rx_valid_d = 1'b1;
            overrun_d  = rx_valid_q && !rx_ack;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // NOTE: the synchroniser resets to 1 (idle line) so reset release never fakes a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= 3'b111;
    else      sync_q <= sync_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp_q      <= '0;
      bit_idx_q   <= 3'd0;
      shreg_q     <= 8'h00;
      smp_lo_q    <= 1'b1;
      smp_mid_q   <= 1'b1;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      samp_q      <= samp_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      smp_lo_q    <= smp_lo_d;
      smp_mid_q   <= smp_mid_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_busy      = (state_q != ST_IDLE);
  assign rx_frame_err = frame_err_q;
  assign rx_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: table of frames at nominal/+-3% rates checked through
// a byte scoreboard, plus hand sequences for glitch, framing, overrun and reset.
module tb_uart_rx;

  // Line rate scaled up so DIV = 8 and one bit is 128 clocks; keeps the run short.
  localparam int unsigned CLK_HZ   = 100_000_000;
  localparam int unsigned BAUD     = 781_250;
  localparam int unsigned OS       = 16;
  localparam int          BIT      = 128;
  localparam int          BIT_FAST = 124;  // sender ~3% fast
  localparam int          BIT_SLOW = 132;  // sender ~3% slow
  localparam int          GAP      = 300;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_pin = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, rx_frame_err, rx_overrun;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  int  valid_rises = 0, ferr_cnt = 0, ovr_cnt = 0, busy_rises = 0;
  logic valid_prev = 1'b0, busy_prev = 1'b0;
  logic auto_ack = 1'b1;
  int   ack_delay = 2;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         bclk;
    int         exp_valid;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[7];

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_pin       (rx_pin),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ack       (rx_ack),
    .rx_busy      (rx_busy),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int bclk);
    rx_pin = 1'b0;
    repeat (bclk) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_pin = d[i];
      repeat (bclk) @(negedge clk);
    end
    rx_pin = stop;
    repeat (bclk) @(negedge clk);
    rx_pin = 1'b1;
  endtask

  // Scoreboard and event counters, sampled on the inactive edge.
  always @(negedge clk) begin
    if (rst && rx_valid && !valid_prev) begin
      valid_rises++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got byte %0h, none expected (t=%0t)", rx_data, $time);
      end else begin
        exp_b = exp_q.pop_front();
        check("sb_data", {24'h0, rx_data}, {24'h0, exp_b});
      end
    end
    if (rx_busy && !busy_prev) busy_rises++;
    if (rx_frame_err) ferr_cnt++;
    if (rx_overrun)   ovr_cnt++;
    valid_prev = rx_valid;
    busy_prev  = rx_busy;
  end

  // Consumer: acks ack_delay clocks after it sees rx_valid high.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_ack && rx_valid && rst) begin
        repeat (ack_delay - 1) @(negedge clk);
        rx_ack = 1'b1;
        check("ack_valid_high", {31'h0, rx_valid}, 32'd1);
        @(negedge clk);
        rx_ack = 1'b0;
        check("ack_clears_valid", {31'h0, rx_valid}, 32'd0);
      end
    end
  end

  initial begin
    int v0, f0, o0, b0;

    vecs[0] = '{8'h55, 1'b1, BIT,      1, 0};
    vecs[1] = '{8'h00, 1'b1, BIT,      1, 0};
    vecs[2] = '{8'hFF, 1'b1, BIT_FAST, 1, 0};
    vecs[3] = '{8'h80, 1'b1, BIT_SLOW, 1, 0};
    vecs[4] = '{8'h01, 1'b1, BIT_FAST, 1, 0};
    vecs[5] = '{8'hC3, 1'b0, BIT,      0, 1};
    vecs[6] = '{8'h3C, 1'b1, BIT_SLOW, 1, 0};

    // Reset state
    repeat (5) @(negedge clk);
    check("rst_data",  {24'h0, rx_data},      32'h0);
    check("rst_valid", {31'h0, rx_valid},     32'h0);
    check("rst_busy",  {31'h0, rx_busy},      32'h0);
    check("rst_ferr",  {31'h0, rx_frame_err}, 32'h0);
    check("rst_ovr",   {31'h0, rx_overrun},   32'h0);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    // Table of frames
    for (int i = 0; i < 7; i++) begin
      v0 = valid_rises; f0 = ferr_cnt; o0 = ovr_cnt;
      if (vecs[i].exp_valid != 0) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].bclk);
      repeat (GAP) @(negedge clk);
      check("vec_valid_count", valid_rises - v0, vecs[i].exp_valid);
      check("vec_ferr_count",  ferr_cnt - f0,    vecs[i].exp_ferr);
      check("vec_ovr_count",   ovr_cnt - o0,     0);
    end

    // 0x55 acked 10 clocks after valid, no flags
    ack_delay = 10;
    v0 = valid_rises; f0 = ferr_cnt; o0 = ovr_cnt;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, BIT);
    repeat (GAP) @(negedge clk);
    check("t1_valid_count", valid_rises - v0, 1);
    check("t1_data", {24'h0, rx_data}, 32'h55);
    check("t1_flags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
    ack_delay = 2;

    // Back-to-back frames, no idle gap
    v0 = valid_rises; b0 = busy_rises;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    send_frame(8'hA5, 1'b1, BIT);
    send_frame(8'h3C, 1'b1, BIT);
    repeat (GAP) @(negedge clk);
    check("t2_valid_count", valid_rises - v0, 2);
    check("t2_busy_rises",  busy_rises - b0,  2);
    check("t2_busy_idle",   {31'h0, rx_busy}, 32'h0);

    // 200 ns glitch aborts in START
    v0 = valid_rises; f0 = ferr_cnt;
    rx_pin = 1'b0;
    repeat (20) @(negedge clk);
    rx_pin = 1'b1;
    check("t3_busy_seen", {31'h0, rx_busy}, 32'h1);
    repeat (BIT) @(negedge clk);
    check("t3_busy_back", {31'h0, rx_busy}, 32'h0);
    check("t3_no_valid",  valid_rises - v0, 0);
    check("t3_no_ferr",   ferr_cnt - f0,    0);

    // Low stop bit, then a good frame
    v0 = valid_rises; f0 = ferr_cnt;
    send_frame(8'h81, 1'b0, BIT);
    repeat (GAP) @(negedge clk);
    check("t4_ferr_once", ferr_cnt - f0,    1);
    check("t4_no_valid",  valid_rises - v0, 0);
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1, BIT);
    repeat (GAP) @(negedge clk);
    check("t4_next_valid", valid_rises - v0, 1);

    // Held-low line gives a single frame error
    f0 = ferr_cnt;
    rx_pin = 1'b0;
    repeat (12 * BIT) @(negedge clk);
    rx_pin = 1'b1;
    repeat (GAP) @(negedge clk);
    check("break_ferr_once", ferr_cnt - f0, 1);

    // Overrun: two bytes without ack
    auto_ack = 1'b0;
    v0 = valid_rises; o0 = ovr_cnt;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, BIT);
    repeat (GAP) @(negedge clk);
    send_frame(8'h22, 1'b1, BIT);
    repeat (GAP) @(negedge clk);
    check("t5_ovr_once",  ovr_cnt - o0,      1);
    check("t5_data",      {24'h0, rx_data},  32'h22);
    check("t5_valid",     {31'h0, rx_valid}, 32'h1);
    check("t5_one_rise",  valid_rises - v0,  1);
    auto_ack = 1'b1;
    repeat (20) @(negedge clk);
    check("t5_acked", {31'h0, rx_valid}, 32'h0);

    // Reset in the middle of DATA, then a fast-rate frame
    v0 = valid_rises;
    rx_pin = 1'b0;
    repeat (5 * BIT + BIT / 2) @(negedge clk);
    check("t6_busy_pre", {31'h0, rx_busy}, 32'h1);
    rst = 1'b0;
    @(negedge clk);
    check("t6_rst_busy",  {31'h0, rx_busy},      32'h0);
    check("t6_rst_valid", {31'h0, rx_valid},     32'h0);
    check("t6_rst_data",  {24'h0, rx_data},      32'h0);
    check("t6_rst_flags", {30'h0, rx_frame_err, rx_overrun}, 32'h0);
    rx_pin = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (BIT) @(negedge clk);
    check("t6_partial_dropped", valid_rises - v0, 0);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1, BIT_FAST);
    repeat (GAP) @(negedge clk);
    check("t6_valid_count", valid_rises - v0, 1);

    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
